// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// ----------------
// This block receives a framed program image on a UART RX line. It writes the
// image into instruction memory one word at a time through a synchronous write
// port. It releases the CPU only after the whole image has arrived with a good
// length and checksum.
//
// Frame: 0xA5, LEN_LO, LEN_HI, N*BYTES_PER_WORD payload bytes (LSB first), CHK
// CHK is the modulo-256 sum of all payload bytes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (board button)
//   uart_rx    serial input, idle high, 8N1, LSB first
//   mem_we     one-cycle write strobe to instruction memory
//   mem_addr   write address (word index)
//   mem_wdata  assembled write word
//   cpu_enable high once a valid image has been loaded (until reset)
//   load_error sticky error flag (until reset)
//   led        active-low status LEDs
//   uart_tx    (LOADER_ECHO_EN only) sends ACK 0x06 on success, NAK 0x15 on error
//
// Optional feature macro: LOADER_ECHO_EN
module uart_boot_loader #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LED_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_enable,
    output logic                  load_error,
    output logic [LED_WIDTH-1:0]  led
`ifdef LOADER_ECHO_EN
    ,
    output logic                  uart_tx
`endif
);

    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BYTES_PER_WORD - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_WAIT_SYNC = 3'd0;
    localparam logic [2:0] ST_LEN_LO    = 3'd1;
    localparam logic [2:0] ST_LEN_HI    = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_CHECK     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;

    // ---------------- RX front end ----------------
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]       rx_st_q, rx_st_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_ferr_q, rx_ferr_d;

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Bit-timing receiver: start-bit recheck at half bit, then mid-bit samples
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = {CNT_W{1'b0}};
                rx_bit_d = 3'd0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d = RX_START;
                end else begin
                    rx_st_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = {CNT_W{1'b0}};
                    // A line that is high again at mid start bit was a glitch
                    if (rx_s2_q) begin
                        rx_st_d = RX_IDLE;
                    end else begin
                        rx_st_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = {CNT_W{1'b0}};
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end else begin
                        rx_st_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = {CNT_W{1'b0}};
                    rx_valid_d = 1'b1;
                    rx_byte_d  = rx_shift_q;
                    rx_ferr_d  = !rx_s2_q;
                    rx_st_d    = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= {CNT_W{1'b0}};
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- Frame FSM ----------------
    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           len_n_s;
    logic [7:0]            sum_q, sum_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [16:0]           words_q, words_d;
    logic                  last_q, last_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_enable_q, cpu_enable_d;
    logic                  load_error_q, load_error_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;

    // Frame parser, word assembler, checksum and next-cycle output values
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        len_n_s     = {rx_byte_q, len_q[7:0]};
        sum_d       = sum_q;
        asm_d       = asm_q;
        byte_idx_d  = byte_idx_q;
        addr_d      = addr_q;
        words_d     = words_q;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_WAIT_SYNC: begin
                if (rx_valid_q && !rx_ferr_q && (rx_byte_q == 8'hA5)) begin
                    state_d    = ST_LEN_LO;
                    sum_d      = 8'h00;
                    byte_idx_d = {BIDX_W{1'b0}};
                    addr_d     = {ADDR_WIDTH{1'b0}};
                    words_d    = 17'd0;
                    last_d     = 1'b0;
                end else begin
                    state_d = ST_WAIT_SYNC;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid_q) begin
                    if (rx_ferr_q) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d[7:0] = rx_byte_q;
                        state_d    = ST_LEN_HI;
                    end
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid_q) begin
                    len_d = len_n_s;
                    if (rx_ferr_q || ({1'b0, len_n_s} > MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else if (len_n_s == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                // Leave DATA only once the final write strobe has been issued
                if (mem_we_q && last_q) begin
                    state_d = ST_CHECK;
                end else if (rx_valid_q) begin
                    if (rx_ferr_q) begin
                        state_d = ST_ERR;
                    end else begin
                        sum_d = sum_q + rx_byte_q;
                        asm_d[{byte_idx_q, 3'b000} +: 8] = rx_byte_q;
                        if (byte_idx_q == BYTE_LAST) begin
                            byte_idx_d  = {BIDX_W{1'b0}};
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = asm_d;
                            // Address wraps to 0 after a full 2^ADDR_WIDTH image
                            addr_d      = addr_q + ADDR_WIDTH'(1);
                            words_d     = words_q + 17'd1;
                            last_d      = ((words_q + 17'd1) == {1'b0, len_q});
                        end else begin
                            byte_idx_d = byte_idx_q + BIDX_W'(1);
                        end
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (rx_valid_q) begin
                    if (!rx_ferr_q && (rx_byte_q == sum_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        cpu_enable_d = (state_d == ST_DONE);
        load_error_d = (state_d == ST_ERR);
        case (state_d)
            ST_DONE: led_d = {{(LED_WIDTH-1){1'b1}}, 1'b0};
            ST_ERR:  led_d = {LED_WIDTH{1'b0}};
            default: led_d = ~words_d[LED_WIDTH-1:0];
        endcase
    end

    // Frame FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT_SYNC;
            len_q        <= 16'd0;
            sum_q        <= 8'h00;
            asm_q        <= {WORD_WIDTH{1'b0}};
            byte_idx_q   <= {BIDX_W{1'b0}};
            addr_q       <= {ADDR_WIDTH{1'b0}};
            words_q      <= 17'd0;
            last_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q  <= {WORD_WIDTH{1'b0}};
            cpu_enable_q <= 1'b0;
            load_error_q <= 1'b0;
            led_q        <= {LED_WIDTH{1'b1}};
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            asm_q        <= asm_d;
            byte_idx_q   <= byte_idx_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            last_q       <= last_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_enable_q <= cpu_enable_d;
            load_error_q <= load_error_d;
            led_q        <= led_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_enable = cpu_enable_q;
    assign load_error = load_error_q;
    assign led        = led_q;

`ifdef LOADER_ECHO_EN
    // ---------------- ACK/NAK transmitter ----------------
    logic             tx_go_q, tx_go_d;
    logic             tx_ack_q, tx_ack_d;
    logic             tx_busy_q, tx_busy_d;
    logic [8:0]       tx_shift_q, tx_shift_d;
    logic [3:0]       tx_left_q, tx_left_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             uart_tx_q, uart_tx_d;

    // One byte per load: DONE and ERR are terminal, so each is entered once
    always_comb begin
        tx_go_d    = 1'b0;
        tx_ack_d   = tx_ack_q;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_left_d  = tx_left_q;
        tx_cnt_d   = tx_cnt_q;
        uart_tx_d  = uart_tx_q;
        if (((state_d == ST_DONE) || (state_d == ST_ERR)) &&
            !((state_q == ST_DONE) || (state_q == ST_ERR))) begin
            tx_go_d  = 1'b1;
            tx_ack_d = (state_d == ST_DONE);
        end else begin
            tx_go_d = 1'b0;
        end
        if (tx_go_q) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, (tx_ack_q ? 8'h06 : 8'h15)};
            tx_left_d  = 4'd9;
            tx_cnt_d   = {CNT_W{1'b0}};
            uart_tx_d  = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = {CNT_W{1'b0}};
                if (tx_left_q == 4'd0) begin
                    tx_busy_d = 1'b0;
                    uart_tx_d = 1'b1;
                end else begin
                    uart_tx_d  = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_left_d  = tx_left_q - 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
        end else begin
            uart_tx_d = 1'b1;
        end
    end

    // Transmitter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_go_q    <= 1'b0;
            tx_ack_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= 9'h1FF;
            tx_left_q  <= 4'd0;
            tx_cnt_q   <= {CNT_W{1'b0}};
            uart_tx_q  <= 1'b1;
        end else begin
            tx_go_q    <= tx_go_d;
            tx_ack_q   <= tx_ack_d;
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_left_q  <= tx_left_d;
            tx_cnt_q   <= tx_cnt_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    assign uart_tx = uart_tx_q;
`endif

endmodule
